// File: rtl/sync_ram_dp_be.sv
// sync_ram_dp_be: simple dual-port RAM with byte-lane writes, selectable read-during-write,
// optional output register, read-valid tracking and a hardware clear engine.
module sync_ram_dp_be #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OUT_REG = 0,
    parameter int RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 we,
    input  logic [DATA_W/8-1:0]  be,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_W-1:0]    din,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_W-1:0]    dout,
    output logic                 rvalid,
    output logic                 busy
);
    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic wr_acc, rd_acc;
    logic [DATA_W-1:0] rd_word;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= (state == CLEAR) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        state_nx = (state == CLEAR) ? ((&cnt) ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    end
    always_comb begin
        busy = (state == CLEAR);
        wr_acc = we & ~busy;
        rd_acc = re & ~busy;
    end
    // Forwarding merges the incoming lanes over the stored word
    always_comb begin
        rd_word = mem[raddr];
        if (RDW_MODE != 0 && wr_acc && waddr == raddr)
            for (int i = 0; i < LANES; i++)
                if (be[i]) rd_word[8*i+:8] = din[8*i+:8];
    end
    always_ff @(posedge clk) begin
        if (busy)
            mem[cnt] <= INIT_VAL;
        else if (we)
            for (int i = 0; i < LANES; i++)
                if (be[i]) mem[waddr][8*i+:8] <= din[8*i+:8];
    end
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] p_d;
            logic p_v;
            // The pipeline stage drains regardless of busy so in-flight reads complete
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_v <= 1'b0;
                    p_d <= '0;
                    rvalid <= 1'b0;
                    dout <= '0;
                end else begin
                    p_v <= rd_acc;
                    if (rd_acc) p_d <= rd_word;
                    rvalid <= p_v;
                    if (p_v) dout <= p_d;
                end
            end
        end else begin : g_direct
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid <= 1'b0;
                    dout <= '0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc) dout <= rd_word;
                end
            end
        end
    endgenerate
endmodule
